// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states,
// byte/half/word little-endian access with alignment checking.
module mem_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned Depth   = 1 << ADDR_W;
    localparam logic [3:0]  WaitCnt = 4'(WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [7:0]          mem_q [Depth];

    logic [ADDR_W-1:0]   a0, a1, a2, a3;
    logic                illegal;
    logic                wr_en;
    logic [31:0]         rd_word;

    // Upper address bits alias onto the low storage range.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_W];

    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    // State and latched-request registers; storage is deliberately not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: accept in idle, count down wait states, one response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr[ADDR_W-1:0];
                    we_d    = we;
                    size_d  = size;
                    wdata_d = wdata;
                    cnt_d   = WaitCnt;
                    state_d = (WaitCnt == 4'd0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Alignment check on the latched request.
    always_comb begin
        illegal = 1'b0;
        case (size_q)
            2'b01:   illegal = addr_q[0];
            2'b10:   illegal = (addr_q[1:0] != 2'b00);
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    // Combinational read of the latched address, zero-extended.
    always_comb begin
        rd_word = '0;
        case (size_q)
            2'b00:   rd_word = {24'd0, mem_q[a0]};
            2'b01:   rd_word = {16'd0, mem_q[a1], mem_q[a0]};
            2'b10:   rd_word = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
            default: rd_word = '0;
        endcase
    end

    assign wr_en = (state_q == StResp) && we_q && !illegal;

    // Store commits on the edge ending the response cycle; untouched bytes are kept.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[a0] <= wdata_q[7:0];
            if (size_q != 2'b00) begin
                mem_q[a1] <= wdata_q[15:8];
            end
            if (size_q == 2'b10) begin
                mem_q[a2] <= wdata_q[23:16];
                mem_q[a3] <= wdata_q[31:24];
            end
        end
    end

    // Outputs are qualified by the response cycle so they read zero otherwise.
    always_comb begin
        busy  = (state_q != StIdle);
        ready = (state_q == StResp);
        err   = ready && illegal;
        rdata = (ready && !illegal && !we_q) ? rd_word : 32'd0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT=2 main, WAIT=0 second instance).
module tb_mem_responder;

    logic        clk;
    logic        reset;

    logic        req, we;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, ready, err;
    logic [31:0] rdata;

    logic        req0, we0;
    logic [1:0]  size0;
    logic [31:0] addr0, wdata0;
    logic        busy0, ready0, err0;
    logic [31:0] rdata0;

    int pass_cnt;
    int total_cnt;

    mem_responder #(.ADDR_W(8), .WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .ready (ready),
        .rdata (rdata),
        .err   (err)
    );

    mem_responder #(.ADDR_W(8), .WAIT(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we0),
        .size  (size0),
        .addr  (addr0),
        .wdata (wdata0),
        .busy  (busy0),
        .ready (ready0),
        .rdata (rdata0),
        .err   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request on the selected instance; returns cycles from accept to ready (-1 if none).
    task automatic access(input bit sel, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        if (sel) begin
            req0 = 1'b1; we0 = w; size0 = s; addr0 = a; wdata0 = d;
        end else begin
            req = 1'b1; we = w; size = s; addr = a; wdata = d;
        end
        @(negedge clk);
        req  = 1'b0;
        req0 = 1'b0;
        lat  = -1;
        rd   = 32'hxxxx_xxxx;
        e    = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (sel ? ready0 : ready) begin
                lat = k;
                rd  = sel ? rdata0 : rdata;
                e   = sel ? err0 : err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, ready, err} !== 3'b000)
            $display("FAIL reset_flags got=%b want=000", {busy, ready, err});
        else pass_cnt++;
        total_cnt++;
        if (rdata !== 32'd0) $display("FAIL reset_rdata got=%h want=00000000", rdata);
        else pass_cnt++;
        total_cnt++;
        if ({busy0, ready0, err0} !== 3'b000 || rdata0 !== 32'd0)
            $display("FAIL reset_dut0 got=%b/%h want=000/00000000", {busy0, ready0, err0}, rdata0);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        int lat;
        logic [31:0] rd;
        logic e;
        logic [1:0] exp_br;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hA1B2C3D4;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req = 1'b0;
            exp_br = (k == 4) ? 2'b00 : ((k == 3) ? 2'b11 : 2'b10);
            total_cnt++;
            if ({busy, ready} !== exp_br)
                $display("FAIL word_wr_cycle%0d busy_ready got=%b want=%b", k, {busy, ready}, exp_br);
            else pass_cnt++;
            if (k == 3) begin
                total_cnt++;
                if (err !== 1'b0 || rdata !== 32'd0)
                    $display("FAIL word_wr_resp got=%b/%h want=0/00000000", err, rdata);
                else pass_cnt++;
            end
        end
        access(1'b0, 1'b0, 2'b10, 32'h10, 32'd0, lat, rd, e);
        total_cnt++;
        if (lat !== 3) $display("FAIL word_rd_latency got=%0d want=3", lat);
        else pass_cnt++;
        total_cnt++;
        if (rd !== 32'hA1B2C3D4 || e !== 1'b0)
            $display("FAIL word_rd got=%h/%b want=a1b2c3d4/0", rd, e);
        else pass_cnt++;
    endtask

    task automatic test_subword();
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b0, 1'b1, 2'b00, 32'h11, 32'h000000EE, lat, rd, e);
        total_cnt++;
        if (e !== 1'b0 || rd !== 32'd0) $display("FAIL byte_wr got=%b/%h want=0/00000000", e, rd);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b10, 32'h10, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'hA1B2EED4) $display("FAIL byte_merge got=%h want=a1b2eed4", rd);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b01, 32'h12, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'h0000A1B2 || e !== 1'b0) $display("FAIL half_rd got=%h/%b want=0000a1b2/0", rd, e);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b00, 32'h13, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'h000000A1 || e !== 1'b0) $display("FAIL byte_rd got=%h/%b want=000000a1/0", rd, e);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b0, 1'b0, 2'b10, 32'h12, 32'd0, lat, rd, e);
        total_cnt++;
        if (lat !== 3 || e !== 1'b1 || rd !== 32'd0)
            $display("FAIL word_misalign got=%0d/%b/%h want=3/1/00000000", lat, e, rd);
        else pass_cnt++;
        access(1'b0, 1'b1, 2'b01, 32'h11, 32'h0000FFFF, lat, rd, e);
        total_cnt++;
        if (e !== 1'b1) $display("FAIL half_misalign_wr got=%b want=1", e);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b10, 32'h10, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'hA1B2EED4) $display("FAIL misalign_no_store got=%h want=a1b2eed4", rd);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b11, 32'h10, 32'd0, lat, rd, e);
        total_cnt++;
        if (e !== 1'b1 || rd !== 32'd0) $display("FAIL size_reserved got=%b/%h want=1/00000000", e, rd);
        else pass_cnt++;
    endtask

    task automatic test_busy();
        int n, first, last;
        // Extra req pulses in WAIT (cycle 2) and RESP (cycle 3) must be ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
        n = 0; first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req = (k == 2 || k == 3);
            if (ready) begin
                n++;
                if (first < 0) first = k;
            end
        end
        req = 1'b0;
        total_cnt++;
        if (n !== 1 || first !== 3) $display("FAIL busy_ignore got=%0d@%0d want=1@3", n, first);
        else pass_cnt++;
        // Held req: pulses at cycles 3, 7, 11.
        @(negedge clk);
        req = 1'b1;
        n = 0; first = -1; last = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ready) begin
                n++;
                if (first < 0) first = k;
                last = k;
            end
        end
        req = 1'b0;
        total_cnt++;
        if (n !== 3 || first !== 3 || last !== 11)
            $display("FAIL back_to_back got=%0d first=%0d last=%0d want=3 first=3 last=11", n, first, last);
        else pass_cnt++;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, n;
        logic [31:0] rd;
        logic e;
        access(1'b0, 1'b1, 2'b10, 32'h20, 32'd0, lat, rd, e);
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL pre_abort_busy got=%b want=1", busy);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || ready !== 1'b0)
            $display("FAIL abort_async got=%b%b want=00", busy, ready);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready) n++;
        end
        total_cnt++;
        if (n !== 0) $display("FAIL abort_no_ready got=%0d want=0", n);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b10, 32'h20, 32'd0, lat, rd, e);
        total_cnt++;
        if (lat !== 3 || rd !== 32'd0) $display("FAIL abort_no_store got=%0d/%h want=3/00000000", lat, rd);
        else pass_cnt++;
    endtask

    task automatic test_wait0();
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b1, 1'b1, 2'b10, 32'h08, 32'h5A6B7C8D, lat, rd, e);
        total_cnt++;
        if (lat !== 1 || e !== 1'b0) $display("FAIL wait0_wr_latency got=%0d/%b want=1/0", lat, e);
        else pass_cnt++;
        access(1'b1, 1'b0, 2'b10, 32'h08, 32'd0, lat, rd, e);
        total_cnt++;
        if (lat !== 1 || rd !== 32'h5A6B7C8D)
            $display("FAIL wait0_rd got=%0d/%h want=1/5a6b7c8d", lat, rd);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] rd;
        logic e;
        access(1'b0, 1'b1, 2'b10, 32'h104, 32'hCAFEF00D, lat, rd, e);
        access(1'b0, 1'b0, 2'b10, 32'h004, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) $display("FAIL addr_wrap got=%h/%b want=cafef00d/0", rd, e);
        else pass_cnt++;
        access(1'b0, 1'b0, 2'b01, 32'hFFFF_FF06, 32'd0, lat, rd, e);
        total_cnt++;
        if (rd !== 32'h0000CAFE) $display("FAIL addr_wrap_half got=%h want=0000cafe", rd);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        req0 = 1'b0; we0 = 1'b0; size0 = 2'b00; addr0 = '0; wdata0 = '0;
        reset = 1'b0;
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_busy();
        test_reset_mid();
        test_wait0();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's data/instruction memory port.
- Accepts one read or write request at a time. Inserts a programmable number of wait states, then returns read data or commits a store.
- Supports byte, halfword and word accesses and flags misaligned or illegal requests.
- Replaces the fixed-latency memory model, so the control FSM can be exercised against a handshaking memory.

Parameters:
- ADDR_W, 8: byte-address bits used. Storage is 2^ADDR_W bytes; upper address bits are ignored.
- WAIT, 2: wait-state cycles between request acceptance and the response cycle (0..15).

Ports:
- clk      in   1   system clock, rising edge
- reset    in   1   asynchronous, active-low reset
- req      in   1   request valid, sampled in IDLE only
- we       in   1   1 = write, 0 = read
- size     in   2   00 byte, 01 halfword, 10 word, 11 reserved
- addr     in   32  byte address
- wdata    in   32  store data; byte/half use the low bits
- busy     out  1   request in progress
- ready    out  1   one-cycle response strobe
- rdata    out  32  load data, zero-extended; valid only while ready=1
- err      out  1   request rejected; valid only while ready=1

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE and the counter clears.
  - busy=0, ready=0, err=0, rdata=0.
  - A pending write is dropped. Storage contents are not reset.
- FSM states and transitions:
  - IDLE: on the edge where req=1, latch addr[ADDR_W-1:0], we, size and wdata; load cnt=WAIT. Go to WAIT, or go straight to RESP if WAIT=0.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, the next state is RESP.
  - RESP: ready=1 for exactly one cycle, then the next state is IDLE.
- Latency: req is sampled at edge N; ready=1 during cycle N+1+WAIT. Total turnaround is WAIT+2 cycles from accept to the next accept.
- busy=1 from the cycle after accept through the RESP cycle inclusive. req while busy=1 (including RESP) is ignored and not queued.
- Back-to-back: a new req is accepted at the edge ending the first IDLE cycle after RESP.
- Byte order is little-endian: the byte at address a occupies word bits 7:0 when a[1:0]=0.
- Alignment check uses the latched address, evaluated in RESP. The request is illegal if any of these hold:
  - size=01 and a[0]=1
  - size=10 and a[1:0]!=0
  - size=11
- Illegal request: err=1 and ready=1, rdata=0, no storage change.
- Legal read:
  - byte: rdata = {24'd0, mem[a]}
  - half: rdata = {16'd0, mem[a+1], mem[a]}
  - word: four bytes, a+3 in bits 31:24.
- Legal write: byte(s) are written at the rising edge ending the RESP cycle. Untouched bytes are preserved. rdata=0 on writes.
- Address wrap: addr bits above ADDR_W-1 are ignored, so 0x100 aliases 0x000 at ADDR_W=8.
- Outside the ready cycle, rdata=0 and err=0.
- Reset asserted during WAIT or RESP aborts the access; no ready pulse is produced.
- Storage: synchronous write, combinational read of the latched address. Power-up contents are undefined; benches write before reading.

Test Plan:
1. WAIT=2. Word write: req=1, we=1, size=10, addr=0x10, wdata=0xA1B2C3D4 at edge 0. Expect busy=1 during cycles 1–3, ready=1 only in cycle 3, err=0. Then word read of 0x10 returns rdata=0xA1B2C3D4 with ready in cycle 3 after its accept.
2. Sub-word access after test 1:
   - byte write 0xEE to 0x11, then word read of 0x10 returns 0xA1B2EED4.
   - half read of 0x12 returns 0x0000A1B2.
   - byte read of 0x13 returns 0x000000A1.
3. Misalignment:
   - word read at 0x12 gives ready=1, err=1, rdata=0.
   - half write at 0x11 with wdata=0xFFFF gives err=1; a following word read of 0x10 is still 0xA1B2EED4.
   - size=11 gives err=1.
4. Busy handling: a second req pulse during WAIT and during the RESP cycle is ignored, giving exactly one ready pulse. A req held high continuously yields a ready pulse every 4 cycles (WAIT=2).
5. Reset mid-operation: issue a word write 0x12345678 to 0x20 and drop reset for 1 cycle during WAIT. Expect busy=0 and ready=0 immediately (asynchronously), and no ready pulse afterwards. A word read of 0x20 returns the prior contents (write 0 first, so expect 0x00000000).
6. Parameter edges:
   - WAIT=0: ready is asserted in the cycle immediately after the accept edge.
   - ADDR_W=8: a word write to 0x104 is read back from 0x004.
